divider_8bits_by_4bits_seq: RTL and testbench
=============================================

DIVIDER_8BITS_BY_4BITS_SEQ -- requirements
Module: divider_8bits_by_4bits_seq

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: ports clk and rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to begin a division, sampled on the rising edge of clk.
REQ-005 dividend  input  8  unsigned dividend, sampled with start.
REQ-006 divisor  input  4  unsigned divisor, sampled with start.
REQ-007 busy  output  1  high while a division is in progress (states RUN and DONE).
REQ-008 done  output  1  one-cycle pulse marking quotient, remainder and div_by_zero as valid.
REQ-009 quotient  output  8  unsigned quotient.
REQ-010 remainder  output  4  unsigned remainder, always less than divisor when divisor is non-zero.
REQ-011 div_by_zero  output  1  high when the divisor captured with start was 0.

Function
REQ-012 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-013 In IDLE with start=1 and divisor!=0, the block SHALL capture the operands, clear the partial remainder (5 bits), clear the 3-bit step counter and move to RUN.
REQ-014 In IDLE with start=1 and divisor=0, the block SHALL go straight to DONE with quotient=8'hFF, remainder=4'h0 and div_by_zero=1.
REQ-015 Each RUN cycle SHALL perform one restoring step, taking dividend bits from MSB first:
  - r = {r[3:0], next dividend bit};
  - if r >= {1'b0, divisor}: r = r - divisor and the quotient bit is 1;
  - otherwise r is unchanged and the quotient bit is 0.
REQ-016 After the 8th RUN step (counter=7) the FSM SHALL enter DONE, with remainder=r[3:0] and div_by_zero=0.
REQ-017 In DONE, done SHALL be 1 for exactly one cycle, and the FSM SHALL then return to IDLE.
REQ-018 Latency SHALL be fixed:
  - divisor non-zero: done is high 9 cycles after the start edge (8 RUN + 1 DONE);
  - divisor zero: done is high in the cycle after the start edge.
REQ-019 start while busy=1 SHALL be ignored, and operand changes during RUN SHALL NOT affect the result.
REQ-020 start in the DONE cycle SHALL be ignored; a new start is accepted only in IDLE, so back-to-back operations are at least one idle cycle apart.
REQ-021 quotient, remainder and div_by_zero SHALL hold their last result until the next DONE.
REQ-022 Boundary results:
  - dividend < divisor gives quotient=0, remainder=dividend[3:0];
  - divisor=1 gives quotient=dividend, remainder=0;
  - the partial remainder SHALL NOT overflow 5 bits.

Reset
REQ-023 On rst=1 the state SHALL be IDLE, and busy, done, quotient, remainder, div_by_zero, the counter and the partial remainder SHALL all be 0.
REQ-024 Reset SHALL take priority over start and over any in-progress step.
REQ-025 Reset mid-RUN SHALL abort the operation, and no done pulse SHALL follow.

Structure
REQ-026 The state encoding (IDLE, RUN, DONE), STEPS=8, DIVIDEND_W=8 and DIVISOR_W=4 SHALL live in the shared divider package.
REQ-027 One combinational sub-module, div_step, SHALL implement a single restoring step: 5-bit partial remainder in, divisor in, new remainder and quotient bit out.
REQ-028 div_step SHALL build its comparison and subtraction on the existing kogge_stone adder cells.

Verification
REQ-029 start, dividend=200, divisor=7 -> done high 9 cycles later, quotient=28, remainder=4, div_by_zero=0.
REQ-030 dividend=255, divisor=1 -> quotient=255, remainder=0; then dividend=5, divisor=9 -> quotient=0, remainder=5.
REQ-031 dividend=13, divisor=0 -> done high the next cycle, div_by_zero=1, quotient=8'hFF, remainder=0.
REQ-032 start with 100/3, then start with 50/5 pulsed in RUN cycle 3 -> only 33 r1 is produced, with a single done pulse.
REQ-033 rst asserted in RUN cycle 4 of 200/7 -> all outputs 0, no done; a subsequent 15/15 -> quotient=1, remainder=0.
REQ-034 Exhaustive sweep of all 4096 operand pairs against the reference model -> quotient*divisor+remainder=dividend and remainder<divisor for every divisor!=0.

Source files
------------

// File: rtl/divider_8bits_by_4bits_seq_pkg.sv
// Shared widths, step count and FSM encoding for the 8-by-4 sequential divider.
package divider_8bits_by_4bits_seq_pkg;

    localparam int unsigned DIVIDEND_W = 8;
    localparam int unsigned DIVISOR_W  = 4;
    localparam int unsigned STEPS      = 8;
    localparam int unsigned REM_W      = DIVISOR_W + 1;
    localparam int unsigned CNT_W      = $clog2(STEPS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: trial-subtract the divisor from the shifted partial remainder.
module div_step
    import divider_8bits_by_4bits_seq_pkg::*;
(
    input  logic [REM_W-1:0]     r_in,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [REM_W-1:0]     r_next_c,
    output logic                 q_bit_c
);

    logic [REM_W-1:0] diff;
    logic             no_borrow;

    // r - d as r + ~d + 1; carry out set means r >= d.
    kogge_stone #(.W(REM_W)) u_sub (
        .a    (r_in),
        .b    (~{1'b0, divisor}),
        .cin  (1'b1),
        .sum  (diff),
        .cout (no_borrow)
    );

    assign q_bit_c  = no_borrow;
    assign r_next_c = no_borrow ? diff : r_in;

endmodule

// File: rtl/kogge_stone.sv
// Parallel-prefix (Kogge-Stone) adder cell: sum = a + b + cin with carry out.
module kogge_stone #(
    parameter int unsigned W = 5
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    // Index 0 carries cin as a generate term; index i+1 is operand bit i.
    logic [W:0] g;
    logic [W:0] p;
    logic [W:0] g_n;
    logic [W:0] p_n;

    always_comb begin
        g   = {a & b, cin};
        p   = {a ^ b, 1'b0};
        g_n = '0;
        p_n = '0;
        for (int d = 1; d <= int'(W); d = d * 2) begin
            g_n = g;
            p_n = p;
            for (int i = d; i <= int'(W); i++) begin
                g_n[i] = g[i] | (p[i] & g[i-d]);
                p_n[i] = p[i] & p[i-d];
            end
            g = g_n;
            p = p_n;
        end
        sum  = (a ^ b) ^ g[W-1:0];
        cout = g[W];
    end

endmodule

// File: rtl/divider_8bits_by_4bits_seq.sv
// Sequential restoring divider: 8-bit dividend by 4-bit divisor, one quotient bit per cycle.
module divider_8bits_by_4bits_seq
    import divider_8bits_by_4bits_seq_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    state_t                state;
    state_t                state_nxt;
    logic                  busy_nxt;
    logic                  done_nxt;
    logic [CNT_W-1:0]      cnt;
    logic [REM_W-1:0]      part_rem;
    logic [REM_W-1:0]      step_in;
    logic [REM_W-1:0]      step_out;
    logic                  q_bit;
    logic [DIVIDEND_W-1:0] dvd_sh;
    logic [DIVISOR_W-1:0]  dvs;
    logic                  last_step;
    logic                  unused_rem_msb;

    // Dividend shifts out MSB-first; quotient bits shift into the vacated LSBs.
    assign step_in        = {part_rem[REM_W-2:0], dvd_sh[DIVIDEND_W-1]};
    assign last_step      = (cnt == CNT_W'(STEPS - 1));
    assign unused_rem_msb = part_rem[REM_W-1] ^ step_out[REM_W-1];

    div_step u_step (
        .r_in     (step_in),
        .divisor  (dvs),
        .r_next_c (step_out),
        .q_bit_c  (q_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state; busy/done decoded from the upcoming state so they register in step with it.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (start) state_nxt = (divisor == '0) ? DONE : RUN;
            RUN:  if (last_step) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        busy_nxt = (state_nxt != IDLE);
        done_nxt = (state_nxt == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            cnt         <= '0;
            part_rem    <= '0;
            dvd_sh      <= '0;
            dvs         <= '0;
        end else begin
            busy <= busy_nxt;
            done <= done_nxt;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        dvd_sh   <= dividend;
                        dvs      <= divisor;
                        part_rem <= '0;
                        cnt      <= '0;
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= '0;
                            div_by_zero <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    part_rem <= step_out;
                    dvd_sh   <= {dvd_sh[DIVIDEND_W-2:0], q_bit};
                    cnt      <= cnt + CNT_W'(1);
                    if (last_step) begin
                        quotient    <= {dvd_sh[DIVIDEND_W-2:0], q_bit};
                        remainder   <= step_out[DIVISOR_W-1:0];
                        div_by_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divider_8bits_by_4bits_seq.sv
// Scoreboard bench for the sequential 8-by-4 divider.
module tb_divider_8bits_by_4bits_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    typedef struct {
        logic [7:0] q;
        logic [3:0] r;
        logic       dz;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    divider_8bits_by_4bits_seq dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    // Push the model result and present a start request for the next rising edge.
    task automatic issue(input logic [7:0] a, input logic [3:0] b);
        exp_t e;
        if (b == 4'd0) begin
            e.q = 8'hFF; e.r = 4'h0; e.dz = 1'b1;
        end else begin
            e.q = 8'(a / b); e.r = 4'(a % b); e.dz = 1'b0;
        end
        sb.push_back(e);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
    endtask

    // lat counts edges from the start edge (1 = that edge) to the edge that raises done.
    task automatic wait_done(output int lat, output logic busy1, output logic after);
        lat   = 0;
        busy1 = 1'bx;
        after = 1'bx;
        while (lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) begin
                start = 1'b0;
                busy1 = busy;
            end
            if (done === 1'b1) break;
        end
        @(posedge clk); #1;
        after = done;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; dividend = 8'd0; divisor = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({busy, done, div_by_zero} !== 3'b000) begin
            bad++; $display("FAIL reset_ctrl got=%b want=000", {busy, done, div_by_zero});
        end
        total++;
        if ({quotient, remainder} !== 12'h000) begin
            bad++; $display("FAIL reset_data got=%h want=000", {quotient, remainder});
        end
        // start while reset is held must be ignored
        @(negedge clk); start = 1'b1; dividend = 8'd200; divisor = 4'd7;
        @(posedge clk); #1;
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL reset_priority busy got=%b want=0", busy);
        end
        @(negedge clk); start = 1'b0; rst = 1'b0;
    endtask

    task automatic test_basic();
        int   lat;
        logic b1, aft;
        exp_t e;
        logic [12:0] held;
        issue(8'd200, 4'd7);
        wait_done(lat, b1, aft);
        e = sb.pop_front();
        total++;
        if (lat !== 9) begin bad++; $display("FAIL basic_latency got=%0d want=9", lat); end
        total++;
        if (b1 !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b want=1", b1); end
        total++;
        if ({quotient, remainder, div_by_zero} !== {e.q, e.r, e.dz} || e.q !== 8'd28 || e.r !== 4'd4) begin
            bad++; $display("FAIL basic_result got=%0d r%0d dz%b want=28 r4 dz0", quotient, remainder, div_by_zero);
        end
        total++;
        if (aft !== 1'b0) begin bad++; $display("FAIL basic_pulse done_next got=%b want=0", aft); end
        repeat (5) @(posedge clk);
        #1;
        held = {quotient, remainder, div_by_zero};
        total++;
        if (held !== {8'd28, 4'd4, 1'b0} || busy !== 1'b0) begin
            bad++; $display("FAIL basic_hold got=%h busy=%b want=%h busy=0", held, busy, {8'd28, 4'd4, 1'b0});
        end
    endtask

    task automatic test_boundaries();
        logic [7:0] as [6] = '{8'd255, 8'd5, 8'd15, 8'd0, 8'd255, 8'd7};
        logic [3:0] bs [6] = '{4'd1,   4'd9, 4'd15, 4'd7, 4'd15,  4'd8};
        for (int k = 0; k < 6; k++) begin
            int   lat;
            logic b1, aft;
            exp_t e;
            issue(as[k], bs[k]);
            wait_done(lat, b1, aft);
            e = sb.pop_front();
            total++;
            if (lat !== 9 || {quotient, remainder, div_by_zero} !== {e.q, e.r, e.dz}) begin
                bad++;
                $display("FAIL boundary_%0d/%0d got=%0d r%0d dz%b lat%0d want=%0d r%0d dz%b lat9",
                         as[k], bs[k], quotient, remainder, div_by_zero, lat, e.q, e.r, e.dz);
            end
        end
    endtask

    task automatic test_div_by_zero();
        int   lat;
        logic b1, aft;
        exp_t e;
        issue(8'd13, 4'd0);
        wait_done(lat, b1, aft);
        e = sb.pop_front();
        total++;
        if (lat !== 1) begin bad++; $display("FAIL dbz_latency got=%0d want=1", lat); end
        total++;
        if ({quotient, remainder, div_by_zero} !== {e.q, e.r, e.dz} || div_by_zero !== 1'b1) begin
            bad++; $display("FAIL dbz_result got=%h r%0d dz%b want=ff r0 dz1", quotient, remainder, div_by_zero);
        end
        total++;
        if (b1 !== 1'b1 || aft !== 1'b0) begin
            bad++; $display("FAIL dbz_flags busy=%b done_next=%b want busy=1 done_next=0", b1, aft);
        end
    endtask

    task automatic test_start_ignored();
        int   n;
        int   pulses = 0;
        int   first  = 0;
        exp_t e;
        logic [12:0] got = '0;
        issue(8'd100, 4'd3);
        for (n = 1; n <= 25; n++) begin
            @(posedge clk); #1;
            if (n == 1) start = 1'b0;
            if (n == 2) begin start = 1'b1; dividend = 8'd50; divisor = 4'd5; end
            if (n == 3) start = 1'b0;
            if (done === 1'b1) begin
                pulses++;
                if (first == 0) begin first = n; got = {quotient, remainder, div_by_zero}; end
            end
        end
        e = sb.pop_front();
        total++;
        if (pulses !== 1 || first !== 9) begin
            bad++; $display("FAIL ignore_pulses got=%0d at %0d want=1 at 9", pulses, first);
        end
        total++;
        if (got !== {e.q, e.r, e.dz}) begin
            bad++; $display("FAIL ignore_result got=%h want=%h", got, {e.q, e.r, e.dz});
        end
    endtask

    task automatic test_back_to_back();
        int   n;
        int   pulses = 0;
        int   lat;
        logic b1, aft;
        exp_t e;
        issue(8'd77, 4'd6);
        for (n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (n == 1) start = 1'b0;
            if (done === 1'b1) break;
        end
        e = sb.pop_front();
        total++;
        if ({quotient, remainder} !== {e.q, e.r}) begin
            bad++; $display("FAIL b2b_first got=%0d r%0d want=%0d r%0d", quotient, remainder, e.q, e.r);
        end
        // start raised during the DONE cycle must be dropped
        start = 1'b1; dividend = 8'd9; divisor = 4'd2;
        @(posedge clk); #1;
        start = 1'b0;
        for (n = 0; n < 12; n++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) pulses++;
        end
        total++;
        if (pulses !== 0) begin bad++; $display("FAIL b2b_done_cycle_start got=%0d want=0", pulses); end
        issue(8'd9, 4'd2);
        wait_done(lat, b1, aft);
        e = sb.pop_front();
        issue(8'd200, 4'd7);
        wait_done(lat, b1, aft);
        total++;
        if ({quotient, remainder} !== 12'h1C4 || e.q !== 8'd4 || lat !== 9) begin
            bad++; $display("FAIL b2b_second got=%0d r%0d lat%0d want=28 r4 lat9", quotient, remainder, lat);
        end
        void'(sb.pop_front());
    endtask

    task automatic test_reset_mid_run();
        int   n;
        int   pulses = 0;
        int   lat;
        logic b1, aft;
        exp_t e;
        issue(8'd200, 4'd7);
        for (n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (n == 1) start = 1'b0;
            if (n == 3) rst = 1'b1;
            if (n == 4) begin
                rst = 1'b0;
                total++;
                if ({busy, done, quotient, remainder, div_by_zero} !== 15'h0) begin
                    bad++; $display("FAIL midrun_reset got=%h want=0", {busy, done, quotient, remainder, div_by_zero});
                end
            end
            if (done === 1'b1) pulses++;
        end
        void'(sb.pop_back());
        total++;
        if (pulses !== 0) begin bad++; $display("FAIL midrun_no_done got=%0d want=0", pulses); end
        issue(8'd15, 4'd15);
        wait_done(lat, b1, aft);
        e = sb.pop_front();
        total++;
        if ({quotient, remainder} !== {e.q, e.r} || quotient !== 8'd1 || lat !== 9) begin
            bad++; $display("FAIL midrun_after got=%0d r%0d lat%0d want=1 r0 lat9", quotient, remainder, lat);
        end
    endtask

    task automatic test_sweep();
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 16; b++) begin
                int   lat;
                logic b1, aft;
                exp_t e;
                issue(8'(a), 4'(b));
                wait_done(lat, b1, aft);
                e = sb.pop_front();
                total++;
                if ({quotient, remainder, div_by_zero} !== {e.q, e.r, e.dz} ||
                    lat !== ((b == 0) ? 1 : 9)) begin
                    bad++;
                    $display("FAIL sweep_%0d/%0d got=%0d r%0d dz%b lat%0d want=%0d r%0d dz%b",
                             a, b, quotient, remainder, div_by_zero, lat, e.q, e.r, e.dz);
                end
                if (b != 0) begin
                    total++;
                    if ((int'(quotient) * b + int'(remainder)) != a || int'(remainder) >= b) begin
                        bad++;
                        $display("FAIL sweep_identity_%0d/%0d got=%0d r%0d", a, b, quotient, remainder);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundaries();
        test_div_by_zero();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid_run();
        test_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
